// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, types and helpers for the FFT output streamer.
//   N       word width exponent, W = 2**N (two's complement words)
//   NPOINT  bins per frame (fixed at 8), IDX_W bits of bin index
//   state_t streamer FSM encoding (IDLE=0, STREAM=1)
//   bin_off bit offset of bin k inside a parallel 8*W frame bus
package fft_pkg;
  localparam int N      = 4;
  localparam int W      = 2 ** N;
  localparam int NPOINT = 8;
  localparam int IDX_W  = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPOINT - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic int bin_off(input int k);
    return W * k;
  endfunction
endpackage

// File: rtl/fft_bin_bank.sv
// fft_bin_bank: 8 x complex W-bit register file holding one FFT frame.
// Ports:
//   clk, rst        clock, synchronous active-high clear of all bins
//   capture         load all 8 bins from in_real/in_image this edge
//   in_real/in_image 8*W parallel frame, bin k at [W*k +: W]
//   sel             bin read select
//   rd_real/rd_image selected bin (read straight from the registers)
module fft_bin_bank
  import fft_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture,
  input  logic [NPOINT*W-1:0]   in_real,
  input  logic [NPOINT*W-1:0]   in_image,
  input  logic [IDX_W-1:0]      sel,
  output logic [W-1:0]          rd_real,
  output logic [W-1:0]          rd_image
);
  logic [W-1:0] in_re_bin [NPOINT];
  logic [W-1:0] in_im_bin [NPOINT];
  logic [W-1:0] re_reg    [NPOINT];
  logic [W-1:0] im_reg    [NPOINT];

  generate
    for (genvar gi = 0; gi < NPOINT; gi++) begin : g_slice
      assign in_re_bin[gi] = in_real[bin_off(gi) +: W];
      assign in_im_bin[gi] = in_image[bin_off(gi) +: W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NPOINT; k++) begin
        re_reg[k] <= '0;
        im_reg[k] <= '0;
      end
    end else if (capture) begin
      for (int k = 0; k < NPOINT; k++) begin
        re_reg[k] <= in_re_bin[k];
        im_reg[k] <= in_im_bin[k];
      end
    end
  end

  assign rd_real  = re_reg[sel];
  assign rd_image = im_reg[sel];
endmodule

// File: rtl/fft_bin_streamer.sv
// fft_bin_streamer: captures one parallel frame of 8 complex FFT bins and
// streams it out one bin per beat (bin 0..7) over valid/ready.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   load, load_ready     frame offer / block can take a frame this cycle
//   in_real, in_image    8*W parallel frame, bin k at [W*k +: W]
//   out_valid, out_ready beat handshake
//   out_real, out_image  current bin, out_index its number
//   out_last             high on the bin 7 beat
// Optional: define FFT_STREAM_CONJ_EN to emit the saturated negation of the
// imaginary part (conjugate output for IFFT-by-conjugation).
module fft_bin_streamer
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  output logic                load_ready,
  input  logic [NPOINT*W-1:0] in_real,
  input  logic [NPOINT*W-1:0] in_image,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_real,
  output logic [W-1:0]        out_image,
  output logic [IDX_W-1:0]    out_index,
  output logic                out_last
);
  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              capture;
  logic              fire;
  logic              accept;
  logic [W-1:0]      bin_image;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    capture    = 1'b0;
    fire       = (state_reg == STREAM) && out_ready;
    // A new frame may land in the same cycle the last beat leaves.
    load_ready = (state_reg == IDLE) || (fire && idx_reg == LAST_IDX);
    accept     = load && load_ready;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          capture    = 1'b1;
          state_next = STREAM;
          idx_next   = '0;
        end
      end
      STREAM: begin
        if (fire) begin
          if (idx_reg == LAST_IDX) begin
            idx_next = '0;
            if (accept) begin
              capture = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  fft_bin_bank u_bank (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture),
    .in_real  (in_real),
    .in_image (in_image),
    .sel      (idx_reg),
    .rd_real  (out_real),
    .rd_image (bin_image)
  );

`ifdef FFT_STREAM_CONJ_EN
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};
  // Most-negative has no positive counterpart; clamp instead of wrapping.
  assign out_image = (bin_image == MOST_NEG) ? MOST_POS : (~bin_image + W'(1));
`else
  assign out_image = bin_image;
`endif

  assign out_valid = (state_reg == STREAM);
  assign out_index = idx_reg;
  assign out_last  = out_valid && (idx_reg == LAST_IDX);
endmodule
